// File: rtl/ascii_rx_fifo_pkg.sv
// Shared system constants for the PS/2 keyboard -> core -> VGA terminal path.
// ps2_ascii, vga_ascii_terminal and ascii_rx_fifo all import this package so
// the core word size and character width are defined in one place.
//   SYS_WORD_MAG : log2 of the core word width
//   ASCII_WIDTH  : width of a decoded character
//   fill_e       : occupancy condition of a character FIFO
package ascii_rx_fifo_pkg;

    localparam int SYS_WORD_MAG = 5;
    localparam int ASCII_WIDTH  = 7;

    typedef enum logic [1:0] {
        FILL_EMPTY,
        FILL_PARTIAL,
        FILL_FULL
    } fill_e;

    function automatic fill_e fill_level(input int unsigned cnt, input int unsigned depth);
        if (cnt == 0) begin
            return FILL_EMPTY;
        end else if (cnt >= depth) begin
            return FILL_FULL;
        end else begin
            return FILL_PARTIAL;
        end
    endfunction

endpackage

// File: rtl/ascii_rx_fifo.sv
// Character FIFO between the PS/2 ASCII decoder and core receiver bus 0.
// Buffers decoded keystrokes so the core can fall behind the keyboard
// without losing characters; characters arriving while full are dropped
// and counted.
// Ports:
//   clk, reset        : single clock, synchronous active-high reset
//   new_code, ascii_code : one-cycle character strobe from ps2_ascii
//   clear             : synchronous flush of contents and statistics
//   send, data        : head entry valid / head character (zero-extended)
//   send_ack          : receiver accepted the head entry; pops it
//   count             : occupancy 0..DEPTH
//   overflow          : sticky, set on any dropped character
//   drop_count        : dropped characters, saturating at 255
module ascii_rx_fifo
    import ascii_rx_fifo_pkg::*;
#(
    parameter int WORD_MAG   = SYS_WORD_MAG,
    parameter int DEPTH_MAG  = 4,
    parameter int WORD_WIDTH = 1 << WORD_MAG
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   new_code,
    input  logic [ASCII_WIDTH-1:0] ascii_code,
    input  logic                   clear,
    output logic                   send,
    input  logic                   send_ack,
    output logic [WORD_WIDTH-1:0]  data,
    output logic [DEPTH_MAG:0]     count,
    output logic                   overflow,
    output logic [7:0]             drop_count
);

    localparam int DEPTH = 1 << DEPTH_MAG;

    logic [ASCII_WIDTH-1:0] mem_q [DEPTH];

    logic [DEPTH_MAG-1:0] wptr_q, wptr_d;
    logic [DEPTH_MAG-1:0] rptr_q, rptr_d;
    logic [DEPTH_MAG:0]   count_q, count_d;
    logic                 send_q, send_d;
    logic                 overflow_q, overflow_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    fill_e level;
    logic  push, pop, drop, wr_en;

    assign level = fill_level(32'(count_q), DEPTH);

    always_comb begin
        pop        = send_q & send_ack;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push       = new_code & ((level != FILL_FULL) | pop);
        drop       = new_code & (level == FILL_FULL) & ~pop;
        wr_en      = push & ~clear & ~reset;

        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (clear) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + DEPTH_MAG'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + DEPTH_MAG'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (DEPTH_MAG+1)'(1);
                2'b01:   count_d = count_q - (DEPTH_MAG+1)'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
        end

        // Registered from next occupancy so send has no combinational input path.
        send_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            send_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            send_q     <= send_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is left unreset; entries are only visible once written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= ascii_code;
        end
    end

    assign send       = send_q;
    assign data       = WORD_WIDTH'(mem_q[rptr_q]);
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_ascii_rx_fifo.sv
// Directed bench for ascii_rx_fifo: single character, ordering, overflow,
// full push/pop, wrap-around, drop saturation, clear and reset.
module tb_ascii_rx_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_code;
    logic [6:0]  ascii_code;
    logic        clear;
    logic        send;
    logic        send_ack;
    logic [31:0] data;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ascii_rx_fifo #(
        .WORD_MAG  (5),
        .DEPTH_MAG (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .new_code   (new_code),
        .ascii_code (ascii_code),
        .clear      (clear),
        .send       (send),
        .send_ack   (send_ack),
        .data       (data),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [6:0] c);
        new_code   = 1'b1;
        ascii_code = c;
        step();
        new_code   = 1'b0;
    endtask

    task automatic ack();
        send_ack = 1'b1;
        step();
        send_ack = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".count"}, 32'(count), 32'd0);
        chk({tag, ".send"}, 32'(send), 32'd0);
        chk({tag, ".ovf"}, 32'(overflow), 32'd0);
        chk({tag, ".drops"}, 32'(drop_count), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        new_code   = 1'b0;
        ascii_code = '0;
        clear      = 1'b0;
        send_ack   = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_idle("reset");

        // ack with nothing valid is ignored
        ack();
        chk("ack_empty.count", 32'(count), 32'd0);

        // single character
        push(7'h41);
        chk("single.send", 32'(send), 32'd1);
        chk("single.data", data, 32'h0000_0041);
        chk("single.count", 32'(count), 32'd1);
        step();
        chk("single.hold", data, 32'h0000_0041);
        ack();
        chk("single.send_after", 32'(send), 32'd0);
        chk("single.count_after", 32'(count), 32'd0);

        // ordering
        push(7'h61);
        push(7'h62);
        push(7'h63);
        chk("order.count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("order.data%0d", i), data, 32'h61 + 32'(i));
            ack();
        end
        chk("order.empty", 32'(send), 32'd0);

        // overflow: 18 pushes into 16 entries
        for (int i = 0; i < 18; i++) push(7'h30 + 7'(i));
        chk("ovf.count", 32'(count), 32'd16);
        chk("ovf.flag", 32'(overflow), 32'd1);
        chk("ovf.drops", 32'(drop_count), 32'd2);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf.drain%0d", i), data, 32'h30 + 32'(i));
            ack();
        end
        chk("ovf.drained", 32'(count), 32'd0);
        chk("ovf.sticky", 32'(overflow), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_idle("ovf.clear");

        // full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push(7'h40 + 7'(i));
        chk("fullpp.full", 32'(count), 32'd16);
        chk("fullpp.head", data, 32'h40);
        new_code   = 1'b1;
        ascii_code = 7'h5A;
        send_ack   = 1'b1;
        step();
        new_code   = 1'b0;
        send_ack   = 1'b0;
        chk("fullpp.count", 32'(count), 32'd16);
        chk("fullpp.ovf", 32'(overflow), 32'd0);
        chk("fullpp.drops", 32'(drop_count), 32'd0);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("fullpp.drain%0d", i), data, 32'h41 + 32'(i));
            ack();
        end
        chk("fullpp.last", data, 32'h5A);
        ack();
        chk("fullpp.empty", 32'(count), 32'd0);

        // wrap-around: pointers start mid-buffer and wrap several times
        for (int i = 0; i < 40; i++) begin
            push(7'h20 + 7'(i));
            chk($sformatf("wrap.data%0d", i), data, 32'h20 + 32'(i));
            ack();
        end
        chk("wrap.count", 32'(count), 32'd0);
        chk("wrap.drops", 32'(drop_count), 32'd0);
        chk("wrap.ovf", 32'(overflow), 32'd0);

        // drop counter saturates at 255
        for (int i = 0; i < 16 + 260; i++) push(7'h7F & 7'(i));
        chk("sat.count", 32'(count), 32'd16);
        chk("sat.drops", 32'(drop_count), 32'd255);
        chk("sat.head", data, 32'h00);

        // clear wins over a coincident push and ack
        new_code   = 1'b1;
        ascii_code = 7'h7E;
        send_ack   = 1'b1;
        clear      = 1'b1;
        step();
        new_code   = 1'b0;
        send_ack   = 1'b0;
        clear      = 1'b0;
        chk_idle("clear");
        step();
        chk("clear.no_push", 32'(count), 32'd0);

        // reset mid-operation with five entries
        for (int i = 0; i < 5; i++) push(7'h50 + 7'(i));
        chk("rst.pre", 32'(count), 32'd5);
        reset      = 1'b1;
        new_code   = 1'b1;
        ascii_code = 7'h11;
        send_ack   = 1'b1;
        step();
        reset      = 1'b0;
        new_code   = 1'b0;
        send_ack   = 1'b0;
        chk_idle("rst");
        push(7'h33);
        chk("rst.after_data", data, 32'h33);
        chk("rst.after_count", 32'(count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
